// File: rtl/hilo_md_unit.sv
`default_nettype none
// ============================================================================
// Module   : hilo_md_unit
// Brief    : Execute-stage HI/LO owner: single-cycle mult/multu, 32-step
//            restoring div/divu with pipeline stall, and mthi/mtlo writes.
// Revision : 1.0 - initial release
// ============================================================================
module hilo_md_unit #(
    parameter int DIV_ITERS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  md_op,
    input  logic        gprtohi,
    input  logic        gprtolo,
    input  logic [31:0] wdata,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        md_stall
);

    localparam int         CNT_W     = $clog2(DIV_ITERS);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DIV_ITERS - 1);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_DIV_RUN  = 2'd1;
    localparam logic [1:0] S_DIV_DONE = 2'd2;

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] counter_q, counter_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      rem_q, rem_d;
    logic [31:0]      quot_q, quot_d;
    logic [31:0]      divisor_q, divisor_d;
    logic             sign_a_q, sign_a_d;
    logic             sign_b_q, sign_b_d;

    logic        w_is_mult, w_is_multu, w_is_div_s, w_is_div_any;
    logic        w_neg_a, w_neg_b;
    logic [31:0] w_abs_a, w_abs_b;
    logic [63:0] w_prod_s, w_prod_u;
    logic [32:0] w_shifted;
    logic        w_ge;
    logic [31:0] w_rem_step, w_quot_step;
    logic [31:0] w_rem_fix, w_quot_fix;

    assign w_is_mult    = (md_op == OP_MULT);
    assign w_is_multu   = (md_op == OP_MULTU);
    assign w_is_div_s   = (md_op == OP_DIV);
    assign w_is_div_any = (md_op == OP_DIV) || (md_op == OP_DIVU);

    assign w_prod_s = $signed({{32{src_a[31]}}, src_a}) * $signed({{32{src_b[31]}}, src_b});
    assign w_prod_u = {32'd0, src_a} * {32'd0, src_b};

    assign w_neg_a = w_is_div_s & src_a[31];
    assign w_neg_b = w_is_div_s & src_b[31];
    assign w_abs_a = w_neg_a ? (~src_a + 32'd1) : src_a;
    assign w_abs_b = w_neg_b ? (~src_b + 32'd1) : src_b;

    // One restoring step; the dividend shifts out of quot_q as quotient bits shift in.
    assign w_shifted   = {rem_q, quot_q[31]};
    assign w_ge        = (w_shifted >= {1'b0, divisor_q});
    assign w_rem_step  = w_ge ? (w_shifted[31:0] - divisor_q) : w_shifted[31:0];
    assign w_quot_step = {quot_q[30:0], w_ge};

    // A zero divisor yields all-ones quotient and the captured dividend as remainder, unsigned.
    always_comb begin
        w_rem_fix  = w_rem_step;
        w_quot_fix = w_quot_step;
        if (divisor_q != 32'd0) begin
            if (sign_a_q ^ sign_b_q) w_quot_fix = ~w_quot_step + 32'd1;
            if (sign_a_q)            w_rem_fix  = ~w_rem_step + 32'd1;
        end
    end

    // State register and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            counter_q <= '0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            rem_q     <= 32'd0;
            quot_q    <= 32'd0;
            divisor_q <= 32'd0;
            sign_a_q  <= 1'b0;
            sign_b_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            rem_q     <= rem_d;
            quot_q    <= quot_d;
            divisor_q <= divisor_d;
            sign_a_q  <= sign_a_d;
            sign_b_q  <= sign_b_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (!flush && w_is_div_any) state_d = S_DIV_RUN;
            S_DIV_RUN: begin
                if (flush)                        state_d = S_IDLE;
                else if (counter_q == LAST_ITER)  state_d = S_DIV_DONE;
            end
            S_DIV_DONE: state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        hi_d      = hi_q;
        lo_d      = lo_q;
        rem_d     = rem_q;
        quot_d    = quot_q;
        divisor_d = divisor_q;
        sign_a_d  = sign_a_q;
        sign_b_d  = sign_b_q;
        counter_d = counter_q;
        case (state_q)
            S_IDLE: begin
                if (!flush) begin
                    if (w_is_mult) begin
                        {hi_d, lo_d} = w_prod_s;
                    end else if (w_is_multu) begin
                        {hi_d, lo_d} = w_prod_u;
                    end else if (w_is_div_any) begin
                        rem_d     = 32'd0;
                        quot_d    = w_abs_a;
                        divisor_d = w_abs_b;
                        sign_a_d  = w_neg_a;
                        sign_b_d  = w_neg_b;
                        counter_d = '0;
                    end else begin
                        if (gprtohi) hi_d = wdata;
                        if (gprtolo) lo_d = wdata;
                    end
                end
            end
            S_DIV_RUN: begin
                rem_d     = w_rem_step;
                quot_d    = w_quot_step;
                counter_d = counter_q + 1'b1;
                if (!flush && counter_q == LAST_ITER) begin
                    hi_d = w_rem_fix;
                    lo_d = w_quot_fix;
                end
            end
            default: ;
        endcase
    end

    // Output logic
    always_comb begin
        md_stall = 1'b0;
        if (!flush) begin
            case (state_q)
                S_IDLE:    md_stall = w_is_div_any;
                S_DIV_RUN: md_stall = 1'b1;
                default:   md_stall = 1'b0;
            endcase
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_hilo_md_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_hilo_md_unit
// Brief    : Directed self-checking bench for hilo_md_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hilo_md_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  md_op;
    logic        gprtohi;
    logic        gprtolo;
    logic [31:0] wdata;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        md_stall;

    int vectors     = 0;
    int miscompares = 0;

    hilo_md_unit #(.DIV_ITERS(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .md_op    (md_op),
        .gprtohi  (gprtohi),
        .gprtolo  (gprtolo),
        .wdata    (wdata),
        .src_a    (src_a),
        .src_b    (src_b),
        .flush    (flush),
        .hi_o     (hi_o),
        .lo_o     (lo_o),
        .md_stall (md_stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        md_op   = 3'b000;
        gprtohi = 1'b0;
        gprtolo = 1'b0;
        flush   = 1'b0;
    endtask

    // Issue a divide, count stall cycles, check results in DIV_DONE, then confirm no restart.
    task automatic run_div(input string tag, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int cycles;
        md_op = op;
        src_a = a;
        src_b = b;
        #1;
        cycles = 0;
        while (md_stall && cycles < 40) begin
            cycles++;
            step();
        end
        check({tag, "_stall_cycles"}, 32'(cycles), 32'd33);
        check({tag, "_hi"}, hi_o, exp_hi);
        check({tag, "_lo"}, lo_o, exp_lo);
        step();
        md_op = 3'b000;
        #1;
        check({tag, "_no_restart"}, {31'd0, md_stall}, 32'd0);
    endtask

    initial begin
        rst   = 1'b1;
        wdata = 32'd0;
        src_a = 32'd0;
        src_b = 32'd0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_hi", hi_o, 32'd0);
        check("reset_lo", lo_o, 32'd0);
        check("reset_stall", {31'd0, md_stall}, 32'd0);

        // mthi and mtlo together
        gprtohi = 1'b1; gprtolo = 1'b1; wdata = 32'h12345678;
        step();
        idle_inputs();
        check("mthilo_hi", hi_o, 32'h12345678);
        check("mthilo_lo", lo_o, 32'h12345678);

        // md_op 101 is treated as none
        md_op = 3'b101; gprtohi = 1'b1; wdata = 32'hCAFE0001;
        #1;
        check("op101_stall", {31'd0, md_stall}, 32'd0);
        step();
        idle_inputs();
        check("op101_hi", hi_o, 32'hCAFE0001);

        // mult overrides gprtohi
        md_op = 3'b001; gprtohi = 1'b1; gprtolo = 1'b1; wdata = 32'hDEADBEEF;
        src_a = 32'hFFFFFFFF; src_b = 32'd2;
        #1;
        check("mult_stall", {31'd0, md_stall}, 32'd0);
        step();
        idle_inputs();
        check("mult_hi", hi_o, 32'hFFFFFFFF);
        check("mult_lo", lo_o, 32'hFFFFFFFE);

        md_op = 3'b010;
        #1;
        check("multu_stall", {31'd0, md_stall}, 32'd0);
        step();
        idle_inputs();
        check("multu_hi", hi_o, 32'h00000001);
        check("multu_lo", lo_o, 32'hFFFFFFFE);

        // flush blocks mtlo
        gprtolo = 1'b1; flush = 1'b1; wdata = 32'h11112222;
        step();
        idle_inputs();
        check("flush_mtlo_lo", lo_o, 32'hFFFFFFFE);

        run_div("divu_100_7", 3'b100, 32'd100, 32'd7, 32'd2, 32'd14);
        run_div("div_m7_2", 3'b011, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_div("div_ovf", 3'b011, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000);
        run_div("div_5_0", 3'b011, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF);
        run_div("divu_5_0", 3'b100, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF);

        // Flush mid-division leaves HI/LO alone
        gprtohi = 1'b1; wdata = 32'hAAAA0000;
        step();
        idle_inputs();
        gprtolo = 1'b1; wdata = 32'h00005555;
        step();
        idle_inputs();
        md_op = 3'b011; src_a = 32'd1000; src_b = 32'd3;
        repeat (11) step();
        check("flush_div_running", {31'd0, md_stall}, 32'd1);
        flush = 1'b1;
        #1;
        check("flush_div_stall", {31'd0, md_stall}, 32'd0);
        step();
        idle_inputs();
        #1;
        check("flush_div_idle", {31'd0, md_stall}, 32'd0);
        repeat (30) step();
        check("flush_div_hi", hi_o, 32'hAAAA0000);
        check("flush_div_lo", lo_o, 32'h00005555);

        // Reset mid-division
        md_op = 3'b100; src_a = 32'd100; src_b = 32'd7;
        repeat (6) step();
        rst   = 1'b1;
        md_op = 3'b000;
        repeat (2) step();
        rst = 1'b0;
        #1;
        check("rst_div_hi", hi_o, 32'd0);
        check("rst_div_lo", lo_o, 32'd0);
        check("rst_div_stall", {31'd0, md_stall}, 32'd0);
        repeat (30) step();
        check("rst_div_hi_late", hi_o, 32'd0);
        check("rst_div_lo_late", lo_o, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
